axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Memory-side neighbour of the instruction cache. Arbitrates the instruction-fetch
//  read port (icache line fills / uncached fetches) and the data read port onto one
//  AXI3 read channel. One transaction outstanding at a time.
//  R beats are broadcast to both masters; each master filters by rid.
// PARAMETERS
//  INST_ID      4'd0  arid/rid tag for instruction-side requests
//  DATA_ID      4'd1  arid/rid tag for data-side requests
//  STARVE_LIMIT 4     max consecutive data grants while inst_req is pending
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   synchronous reset, active-low
//  inst_req     in   1   inst read request; level, held until its last beat
//  inst_araddr  in   32  inst burst start address
//  inst_arlen   in   4   inst burst length-1 (0 = single word, 3 = 4-word line)
//  data_req     in   1   data read request; same rules as inst_req
//  data_araddr  in   32  data burst start address
//  data_arlen   in   4   data burst length-1
//  rdata        out  32  broadcast read data
//  rid          out  4   broadcast beat tag
//  rvalid       out  1   broadcast beat valid (axi_rvalid & axi_rready)
//  rlast        out  1   broadcast last beat
//  busy         out  1   high whenever state != IDLE
//  rd_err       out  1   sticky: set on rresp!=0 or rid!=granted id; cleared by reset only
//  arid/araddr/arlen out 4/32/4  AXI AR payload, registered at grant
//  arsize       out  3   constant 3'b010
//  arburst      out  2   constant 2'b01 (INCR)
//  arvalid      out  1   AXI AR valid
//  arready      in   1   AXI AR ready
//  axi_rid/axi_rdata/axi_rresp in 4/32/2  AXI R payload
//  axi_rlast/axi_rvalid        in 1/1     AXI R last/valid
//  axi_rready   out  1   AXI R ready
// BEHAVIOUR
//  Reset: state=IDLE; arvalid=0, axi_rready=0, rvalid=0, busy=0, rd_err=0;
//   arid/araddr/arlen=0; streak=0.
//  States:
//  - IDLE: sample requests at posedge; may latch and move to AR:
//    - both pending: data wins unless streak==STARVE_LIMIT, then inst wins.
//    - single request: that one wins.
//    - latch arid/araddr/arlen from winner.
//    - streak: +1 on data grant while inst_req=1; 0 on inst grant or data grant with inst_req=0.
//  - AR: arvalid=1; payload stable; on arready -> R. Request drop in AR ignored
//    (AXI forbids retracting arvalid); burst runs to completion.
//  - R: axi_rready=1; forward axi_rdata/rid/rlast, rvalid=axi_rvalid.
//    On axi_rvalid & axi_rlast & rid==granted -> IDLE.
//  Arbitration: IDLE is revisited for >=1 cycle after every last beat. The master's
//   request, dropped combinationally on the last beat, is therefore never re-granted.
//   Minimum request-to-arvalid latency is 1 cycle.
//  Outputs: rdata/rid/rlast are combinational pass-through; qualify them with rvalid.
//   rvalid=0 outside R.
//  Errors:
//  - beat with axi_rid != granted id: set rd_err; beat still forwarded unchanged;
//    its rlast does not end R.
//  - rresp!=0: set rd_err; beat still forwarded normally.
//  - A master cancelling mid-burst (e.g. pipeline clear) does not abort;
//    remaining beats are still broadcast and consumed.
//  Simultaneous: axi_rvalid in AR state is not accepted (rready=0).
//  Reset mid-burst: returns to IDLE next cycle. The interconnect is reset with the core.
// TESTING
//  1 inst_req, addr 0x1FC0_0014, len 3, arready same cycle -> arvalid 1 cycle later,
//    araddr 0x1FC0_0014, arid 0; 4 beats forwarded with rid 0; IDLE after beat 4.
//  2 inst_req and data_req rise together -> data granted first (arid 1); inst granted
//    in the IDLE cycle after data's last beat.
//  3 data_req held continuously, inst_req pending -> after 4 data grants the 5th grant
//    is inst (arid 0).
//  4 inst_req dropped after beat 2 of 4 -> beats 3-4 still accepted and forwarded;
//    no new AR; IDLE after beat 4.
//  5 arready held low 5 cycles -> arvalid and payload stable for all 5 cycles; R
//    entered on the arready cycle.
//  6 beat with axi_rresp=2'b10 -> rd_err=1 from the next cycle and stays 1 through
//    later clean bursts until rst=0.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI3 read-address / read-data channel bundle between the read arbiter and the
// memory-side interconnect.
//   master modport: arbiter side (drives AR payload/valid and R ready)
//   slave modport : interconnect side (drives arready and the R beat)
interface axi_rd_arbiter_if;
  // AR channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, axi_rready,
    input  arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, axi_rready,
    output arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Read arbiter between the instruction-fetch port and the data read port, sharing a
// single AXI3 read channel with one transaction outstanding at a time. R beats are
// broadcast to both masters, which filter on rid.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   inst_req/araddr/arlen         instruction-side request (level, held to last beat)
//   data_req/araddr/arlen         data-side request (same rules)
//   rdata/rid/rvalid/rlast        broadcast beat (rdata/rid/rlast qualified by rvalid)
//   busy                          high whenever a transaction is in progress
//   rd_err                        sticky error: bad rresp or unexpected rid
//   axi                           AXI AR/R channel (master side)
module axi_rd_arbiter #(
  parameter logic [3:0]  INST_ID      = 4'd0,
  parameter logic [3:0]  DATA_ID      = 4'd1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_req,
  input  logic [31:0]              inst_araddr,
  input  logic [3:0]               inst_arlen,
  input  logic                     data_req,
  input  logic [31:0]              data_araddr,
  input  logic [3:0]               data_arlen,
  output logic [31:0]              rdata,
  output logic [3:0]               rid,
  output logic                     rvalid,
  output logic                     rlast,
  output logic                     busy,
  output logic                     rd_err,
  axi_rd_arbiter_if.master         axi
);

  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAr   = 2'd1;
  localparam logic [1:0] StR    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [3:0]         arid_q, arid_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [3:0]         arlen_q, arlen_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               rd_err_q, rd_err_d;

  logic grant_data;
  logic grant_inst;
  logic beat;
  logic rid_bad;

  always_comb begin
    // Data wins ties until it has been granted STARVE_LIMIT times in a row over a
    // waiting instruction request.
    grant_data = data_req && (!inst_req || (streak_q != StreakMax));
    grant_inst = inst_req && !grant_data;
    beat       = (state_q == StR) && axi.axi_rvalid;
    rid_bad    = beat && (axi.axi_rid != arid_q);

    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    streak_d = streak_q;
    rd_err_d = rd_err_q | (beat && ((axi.axi_rresp != 2'b00) || rid_bad));

    case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d  = StAr;
          arid_d   = DATA_ID;
          araddr_d = data_araddr;
          arlen_d  = data_arlen;
          streak_d = inst_req ? streak_q + 1'b1 : '0;
        end else if (grant_inst) begin
          state_d  = StAr;
          arid_d   = INST_ID;
          araddr_d = inst_araddr;
          arlen_d  = inst_arlen;
          streak_d = '0;
        end
      end
      StAr: begin
        // Requests are not re-examined here; an issued AR cannot be retracted.
        if (axi.arready) state_d = StR;
      end
      StR: begin
        // A stray-id last beat is forwarded but does not close our burst.
        if (beat && !rid_bad && axi.axi_rlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      streak_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      streak_q <= streak_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign axi.arid       = arid_q;
  assign axi.araddr     = araddr_q;
  assign axi.arlen      = arlen_q;
  assign axi.arsize     = 3'b010;
  assign axi.arburst    = 2'b01;
  assign axi.arvalid    = (state_q == StAr);
  assign axi.axi_rready = (state_q == StR);

  assign rdata  = axi.axi_rdata;
  assign rid    = axi.axi_rid;
  assign rlast  = axi.axi_rlast;
  assign rvalid = beat;
  assign busy   = (state_q != StIdle);
  assign rd_err = rd_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios, a transaction-level reference model
// checked every cycle, and literal expectations at key points of each scenario.
module tb_axi_rd_arbiter;

  localparam int unsigned StarveLimit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_araddr;
  logic [3:0]  inst_arlen;
  logic        data_req;
  logic [31:0] data_araddr;
  logic [3:0]  data_arlen;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic        rvalid;
  logic        rlast;
  logic        busy;
  logic        rd_err;

  axi_rd_arbiter_if axi ();

  axi_rd_arbiter #(
    .INST_ID      (4'd0),
    .DATA_ID      (4'd1),
    .STARVE_LIMIT (StarveLimit)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_araddr (inst_araddr),
    .inst_arlen  (inst_arlen),
    .data_req    (data_req),
    .data_araddr (data_araddr),
    .data_arlen  (data_arlen),
    .rdata       (rdata),
    .rid         (rid),
    .rvalid      (rvalid),
    .rlast       (rlast),
    .busy        (busy),
    .rd_err      (rd_err),
    .axi         (axi)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level reference: one outstanding read, described by who owns it,
  // its AR payload, and whether the address phase has completed.
  bit          m_active;
  bit          m_ar_done;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [3:0]  m_len;
  int          m_streak;
  bit          m_err;

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      m_active = 0; m_ar_done = 0; m_id = '0; m_addr = '0; m_len = '0;
      m_streak = 0; m_err = 0;
    end else if (!m_active) begin
      if (data_req && (!inst_req || m_streak < StarveLimit)) begin
        m_active = 1; m_ar_done = 0;
        m_id = 4'd1; m_addr = data_araddr; m_len = data_arlen;
        m_streak = inst_req ? m_streak + 1 : 0;
      end else if (inst_req) begin
        m_active = 1; m_ar_done = 0;
        m_id = 4'd0; m_addr = inst_araddr; m_len = inst_arlen;
        m_streak = 0;
      end
    end else if (!m_ar_done) begin
      m_ar_done = axi.arready;
    end else if (axi.axi_rvalid) begin
      if (axi.axi_rresp != 2'b00 || axi.axi_rid != m_id) m_err = 1;
      if (axi.axi_rlast && axi.axi_rid == m_id) m_active = 0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, m_active);
      chk("arvalid", axi.arvalid, m_active && !m_ar_done);
      chk("axi_rready", axi.axi_rready, m_active && m_ar_done);
      chk("rvalid", rvalid, m_active && m_ar_done && axi.axi_rvalid);
      chk("rd_err", rd_err, m_err);
      chk("arid", axi.arid, m_id);
      chk("araddr", axi.araddr, m_addr);
      chk("arlen", axi.arlen, m_len);
      chk("arsize", axi.arsize, 3'b010);
      chk("arburst", axi.arburst, 2'b01);
      if (m_active && m_ar_done && axi.axi_rvalid) begin
        chk("rdata", rdata, axi.axi_rdata);
        chk("rid", rid, axi.axi_rid);
        chk("rlast", rlast, axi.axi_rlast);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for AR, hold arready low for 'delay' cycles checking payload, then accept.
  task automatic ar_phase(input int delay, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len);
    int n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ar_wait", axi.arvalid, 1'b1);
    for (int i = 0; i < delay; i++) begin
      chk("ar_hold_valid", axi.arvalid, 1'b1);
      chk("ar_hold_id", axi.arid, id);
      chk("ar_hold_addr", axi.araddr, addr);
      chk("ar_hold_len", axi.arlen, len);
      tick();
    end
    chk("ar_id", axi.arid, id);
    chk("ar_addr", axi.araddr, addr);
    chk("ar_len", axi.arlen, len);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("r_entered", axi.axi_rready, 1'b1);
  endtask

  // Drive nbeats beats; beat index bad_beat carries SLVERR; inst_req drops after
  // beat number drop_inst_after (1-based, 0 = never).
  task automatic r_phase(input logic [3:0] id, input int nbeats, input int bad_beat,
                         input int drop_inst_after, input logic [31:0] base);
    for (int i = 0; i < nbeats; i++) begin
      axi.axi_rvalid = 1'b1;
      axi.axi_rid    = id;
      axi.axi_rdata  = base + i;
      axi.axi_rlast  = (i == nbeats - 1);
      axi.axi_rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      #1;
      chk("beat_fwd", rvalid, 1'b1);
      chk("beat_rid", rid, id);
      tick();
      if (drop_inst_after != 0 && i == drop_inst_after - 1) inst_req = 1'b0;
    end
    axi.axi_rvalid = 1'b0;
    axi.axi_rlast  = 1'b0;
    axi.axi_rresp  = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ids [5];
    exp_ids = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0};

    rst = 1'b0;
    inst_req = 1'b0; inst_araddr = '0; inst_arlen = '0;
    data_req = 1'b0; data_araddr = '0; data_arlen = '0;
    axi.arready = 1'b0; axi.axi_rid = '0; axi.axi_rdata = '0; axi.axi_rresp = '0;
    axi.axi_rlast = 1'b0; axi.axi_rvalid = 1'b0;

    tick();
    checking = 1'b1;
    repeat (2) tick();
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_rready", axi.axi_rready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", rd_err, 1'b0);
    chk("rst_araddr", axi.araddr, 32'h0);
    rst = 1'b1;
    tick();

    // 1: single inst line fill, one-cycle request-to-arvalid latency.
    inst_araddr = 32'h1FC0_0014; inst_arlen = 4'd3; inst_req = 1'b1;
    tick();
    chk("s1_latency", axi.arvalid, 1'b1);
    ar_phase(0, 4'd0, 32'h1FC0_0014, 4'd3);
    r_phase(4'd0, 4, -1, 0, 32'hA000_0000);
    chk("s1_idle", busy, 1'b0);
    inst_req = 1'b0;
    tick();

    // 2: simultaneous requests -> data first, then inst right after.
    data_araddr = 32'h0000_8000; data_arlen = 4'd1;
    inst_araddr = 32'h1FC0_0040; inst_arlen = 4'd3;
    inst_req = 1'b1; data_req = 1'b1;
    tick();
    ar_phase(0, 4'd1, 32'h0000_8000, 4'd1);
    r_phase(4'd1, 2, -1, 0, 32'hB000_0000);
    data_req = 1'b0;
    chk("s2_idle", busy, 1'b0);
    tick();
    chk("s2_inst_arvalid", axi.arvalid, 1'b1);
    chk("s2_inst_arid", axi.arid, 4'd0);
    ar_phase(0, 4'd0, 32'h1FC0_0040, 4'd3);
    r_phase(4'd0, 4, -1, 0, 32'hC000_0000);
    inst_req = 1'b0;
    tick();

    // 3: data held continuously starves inst for at most four grants.
    inst_req = 1'b1; data_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (exp_ids[g] == 4'd1) begin
        ar_phase(0, 4'd1, 32'h0000_8000, 4'd1);
        r_phase(4'd1, 2, -1, 0, 32'hD000_0000 + 32'(g * 16));
      end else begin
        ar_phase(0, 4'd0, 32'h1FC0_0040, 4'd3);
        r_phase(4'd0, 4, -1, 0, 32'hD000_0000 + 32'(g * 16));
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // 4: inst cancels after beat 2; burst still completes, no new AR.
    inst_araddr = 32'h1FC0_0100; inst_arlen = 4'd3; inst_req = 1'b1;
    tick();
    ar_phase(0, 4'd0, 32'h1FC0_0100, 4'd3);
    r_phase(4'd0, 4, -1, 2, 32'hE000_0000);
    chk("s4_idle", busy, 1'b0);
    tick();
    chk("s4_no_ar", axi.arvalid, 1'b0);
    tick();
    chk("s4_no_ar2", axi.arvalid, 1'b0);

    // 5: arready stalled five cycles.
    data_araddr = 32'h0000_9000; data_arlen = 4'd0; data_req = 1'b1;
    tick();
    ar_phase(5, 4'd1, 32'h0000_9000, 4'd0);
    r_phase(4'd1, 1, -1, 0, 32'hF000_0000);
    data_req = 1'b0;
    tick();

    // 6: SLVERR beat makes rd_err sticky across a later clean burst.
    inst_req = 1'b1;
    tick();
    ar_phase(0, 4'd0, 32'h1FC0_0100, 4'd3);
    r_phase(4'd0, 4, 1, 0, 32'h1234_0000);
    inst_req = 1'b0;
    chk("s6_err_set", rd_err, 1'b1);
    data_req = 1'b1;
    tick();
    ar_phase(0, 4'd1, 32'h0000_9000, 4'd0);
    r_phase(4'd1, 1, -1, 0, 32'h5678_0000);
    data_req = 1'b0;
    chk("s6_err_sticky", rd_err, 1'b1);
    tick();

    // Stray-id last beat does not end the burst; reset mid-burst returns to idle.
    inst_req = 1'b1;
    tick();
    ar_phase(0, 4'd0, 32'h1FC0_0100, 4'd3);
    axi.axi_rvalid = 1'b1; axi.axi_rid = 4'd5; axi.axi_rdata = 32'hDEAD_BEEF;
    axi.axi_rlast = 1'b1; axi.axi_rresp = 2'b00;
    tick();
    chk("stray_busy", busy, 1'b1);
    chk("stray_rready", axi.axi_rready, 1'b1);
    axi.axi_rid = 4'd0; axi.axi_rlast = 1'b0; axi.axi_rdata = 32'h0000_0001;
    tick();
    axi.axi_rvalid = 1'b0;
    inst_req = 1'b0;
    rst = 1'b0;
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_err", rd_err, 1'b0);
    chk("midrst_rready", axi.axi_rready, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    chk("final_idle", busy, 1'b0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
